// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel push-button front end. Each channel is built from:
//     - a 2-flop synchroniser;
//     - a stable-count debouncer;
//     - a hold-time FSM that produces single-cycle press, release, long-press
//       and auto-repeat pulses.
//   Channels share nothing.
//
// Ports
//   clk           : system clock
//   rst_n         : asynchronous, active-low reset
//   key_in        : raw asynchronous button inputs (polarity set by ACTIVE_LOW)
//   key_state     : debounced level, 1 = pressed
//   press_pulse   : 1-cycle pulse on an accepted press
//   release_pulse : 1-cycle pulse on an accepted release
//   long_pulse    : 1-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse  : 1-cycle pulse every REPEAT_CYCLES while held past long
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned LONG_CYCLES     = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 200000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    localparam logic        InactiveLvl = (ACTIVE_LOW != 0);
    localparam logic        RepeatOn    = (REPEAT_EN != 0);
    localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LongW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam int unsigned RepW  = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    // One hold counter serves both the HELD and LONG phases.
    localparam int unsigned HoldW = (LongW > RepW) ? LongW : RepW;

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] LongLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [HoldW-1:0] RepLast  = HoldW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StLong} hold_state_e;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic             sync1_q, sync2_q;
        logic             pressed_now;
        logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
        logic             state_q, state_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        hold_state_e      hold_q, hold_d;
        logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
        logic             long_q, long_d;
        logic             repeat_q, repeat_d;

        // Synchroniser idles at the released level so reset never looks like a press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= InactiveLvl;
                sync2_q <= InactiveLvl;
            end else begin
                sync1_q <= key_in[g];
                sync2_q <= sync1_q;
            end
        end

        assign pressed_now = sync2_q ^ InactiveLvl;

        // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
        always_comb begin
            deb_cnt_d = '0;
            state_d   = state_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (pressed_now != state_q) begin
                if (deb_cnt_q == DebLast) begin
                    state_d   = pressed_now;
                    press_d   = pressed_now;
                    release_d = ~pressed_now;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_q <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                deb_cnt_q <= deb_cnt_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Hold FSM: state register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q     <= StIdle;
                hold_cnt_q <= '0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                hold_q     <= hold_d;
                hold_cnt_q <= hold_cnt_d;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
            end
        end

        // Hold FSM: next state. An accepted release overrides everything.
        always_comb begin
            hold_d     = hold_q;
            hold_cnt_d = hold_cnt_q;
            if (release_d) begin
                hold_d     = StIdle;
                hold_cnt_d = '0;
            end else begin
                unique case (hold_q)
                    StIdle: begin
                        hold_cnt_d = '0;
                        if (press_d) begin
                            hold_d = StHeld;
                        end
                    end
                    StHeld: begin
                        if (hold_cnt_q == LongLast) begin
                            hold_d     = StLong;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    StLong: begin
                        if (!RepeatOn || hold_cnt_q == RepLast) begin
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        hold_d     = StIdle;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end

        // Hold FSM: outputs, registered one edge later; a coincident release suppresses them.
        always_comb begin
            long_d   = (hold_q == StHeld) && (hold_cnt_q == LongLast) && !release_d;
            repeat_d = RepeatOn && (hold_q == StLong) && (hold_cnt_q == RepLast) && !release_d;
        end

        assign key_state[g]     = state_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign long_pulse[g]    = long_q;
        assign repeat_pulse[g]  = repeat_q;
    end

endmodule
